// File: rtl/or16_accum_if.sv
// Handshake bundle for or16_accum: an input word stream and an output result stream.
//
// Both streams use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both high. The producer holds its data
// stable while valid is high and ready is low. Ready may depend
// combinationally on the consumer's state, but valid never depends on ready.
interface or16_accum_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_count;
  logic             out_full;

  // Upstream/downstream side: drives words in and accepts results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_full
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_full
  );
endinterface

// File: rtl/or16_accum.sv
// OR-reduces frames of up to BEATS words into one result word. A frame closes
// after BEATS words or on an accepted word carrying in_last. The result is held
// until drained, and a new frame may start on the drain cycle itself, so frames
// stream back to back with no bubble while out_ready stays high.
module or16_accum #(
  parameter int WIDTH = 16,
  parameter int BEATS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  or16_accum_if.slave   bus,
  output logic          dbg_state
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] BEATS_C = 8'(BEATS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       cnt_inc;
  logic             in_ready;
  logic             accept;
  logic             drain;

  // Words are refused throughout reset; otherwise accept while accumulating,
  // or while holding only when the held result drains in the same cycle.
  assign in_ready = rst_n && ((state == ACCUM) || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign drain    = (state == HOLD) && bus.out_ready;
  assign cnt_inc  = cnt + 8'd1;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = acc;
  assign bus.out_count = cnt;
  assign bus.out_full  = &acc;
  assign dbg_state     = state;

  // Next-state logic: accumulate, close the frame, or drain and optionally restart.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      ACCUM: begin
        if (accept) begin
          acc_nxt = (cnt == 8'd0) ? bus.in_data : (acc | bus.in_data);
          cnt_nxt = cnt_inc;
          if ((cnt_inc == BEATS_C) || bus.in_last) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (drain) begin
          if (accept) begin
            // First word of the next frame lands in the drain cycle.
            acc_nxt   = bus.in_data;
            cnt_nxt   = 8'd1;
            state_nxt = ((BEATS_C == 8'd1) || bus.in_last) ? HOLD : ACCUM;
          end else begin
            acc_nxt   = '0;
            cnt_nxt   = 8'd0;
            state_nxt = ACCUM;
          end
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // State register; reset discards any partial or undrained frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_or16_accum.sv
// Self-checking bench for or16_accum: a BEATS=4 instance exercised with
// directed frames, backpressure and mid-frame reset, plus a BEATS=1 instance.
module tb_or16_accum;

  logic clk;
  logic rst_n;
  logic dbg0;
  logic dbg1;

  or16_accum_if #(.WIDTH(16)) bus0 ();
  or16_accum_if #(.WIDTH(16)) bus1 ();

  or16_accum #(.WIDTH(16), .BEATS(4)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0.slave),
    .dbg_state (dbg0)
  );

  or16_accum #(.WIDTH(16), .BEATS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1.slave),
    .dbg_state (dbg1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard: BEATS=4 ----------------
  // Entry layout: {full, count[7:0], data[15:0]}.
  logic [24:0] exp_q[$];
  logic [15:0] m_acc;
  logic [7:0]  m_cnt;

  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst_n) begin
      m_acc = '0;
      m_cnt = '0;
      exp_q.delete();
    end else begin
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q.size() == 0) begin
          check("b4_unexpected_result", 32'(bus0.out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("b4_data",  32'(bus0.out_data),  32'(e[15:0]));
          check("b4_count", 32'(bus0.out_count), 32'(e[23:16]));
          check("b4_full",  32'(bus0.out_full),  32'(e[24]));
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        m_acc = m_acc | bus0.in_data;
        m_cnt = m_cnt + 8'd1;
        if (m_cnt == 8'd4 || bus0.in_last) begin
          exp_q.push_back({(m_acc == 16'hFFFF), m_cnt, m_acc});
          m_acc = '0;
          m_cnt = '0;
        end
      end
    end
  end

  // ---------------- scoreboard: BEATS=1 ----------------
  logic [15:0] exp1_q[$];
  int drains1 = 0;
  int run1 = 0;
  int max_run1 = 0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      exp1_q.delete();
      run1 = 0;
    end else begin
      if (bus1.out_valid) begin
        run1++;
        if (run1 > max_run1) max_run1 = run1;
      end else begin
        run1 = 0;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        drains1++;
        if (exp1_q.size() == 0) begin
          check("b1_unexpected_result", 32'(bus1.out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp1_q.pop_front();
          check("b1_data",  32'(bus1.out_data),  32'(e));
          check("b1_count", 32'(bus1.out_count), 32'd1);
          check("b1_full",  32'(bus1.out_full),  32'(e == 16'hFFFF));
        end
      end
      if (bus1.in_valid && bus1.in_ready) begin
        exp1_q.push_back(bus1.in_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one word on bus0 and returns just after the edge that accepts it.
  task automatic send0(input logic [15:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    bus0.in_last  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] v1 [3];

  initial begin
    v1[0] = 16'h02F3;
    v1[1] = 16'h0000;
    v1[2] = 16'hFFFF;

    rst_n          = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 16'h1234;
    bus0.in_last   = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 16'h0000;
    bus1.in_last   = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset held two cycles with in_valid high.
    cycle();
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready",  32'(bus0.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
      check("rst_out_data",  32'(bus0.out_data),  32'h0000);
      check("rst_out_count", 32'(bus0.out_count), 32'd0);
      check("rst_out_full",  32'(bus0.out_full),  32'd0);
      check("rst_state",     32'(dbg0),           32'd0);
      cycle();
    end
    rst_n         = 1'b1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("rel_in_ready",  32'(bus0.in_ready),  32'd1);
    check("rel_out_valid", 32'(bus0.out_valid), 32'd0);
    cycle();

    // Full frame of four words.
    send0(16'h02F3, 1'b0);
    send0(16'h0000, 1'b0);
    send0(16'h0100, 1'b0);
    send0(16'h8000, 1'b0);
    @(negedge clk);
    check("full_latency_valid", 32'(bus0.out_valid), 32'd1);
    check("full_data",          32'(bus0.out_data),  32'h83F3);
    check("full_count",         32'(bus0.out_count), 32'd4);
    check("full_not_full",      32'(bus0.out_full),  32'd0);
    cycle();
    @(negedge clk);
    check("full_pulse_1cyc", 32'(bus0.out_valid), 32'd0);
    cycle();

    // Early end with saturation.
    send0(16'h02F3, 1'b0);
    send0(16'hFFFF, 1'b1);
    @(negedge clk);
    check("early_valid", 32'(bus0.out_valid), 32'd1);
    check("early_data",  32'(bus0.out_data),  32'hFFFF);
    check("early_count", 32'(bus0.out_count), 32'd2);
    check("early_full",  32'(bus0.out_full),  32'd1);
    cycle();

    // Backpressure: result held while a new word waits.
    bus0.out_ready = 1'b0;
    send0(16'h1111, 1'b0);
    send0(16'h2222, 1'b0);
    send0(16'h0004, 1'b0);
    send0(16'h0008, 1'b0);
    bus0.in_valid = 1'b1;
    bus0.in_data  = 16'h0AAA;
    bus0.in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready",  32'(bus0.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus0.out_valid), 32'd1);
      check("bp_out_data",  32'(bus0.out_data),  32'h333F);
      check("bp_out_count", 32'(bus0.out_count), 32'd4);
      cycle();
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_in_ready", 32'(bus0.in_ready), 32'd1);
    cycle();
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("bp_restart_count", 32'(bus0.out_count), 32'd1);
    check("bp_restart_valid", 32'(bus0.out_valid), 32'd0);
    cycle();
    send0(16'h0100, 1'b0);
    send0(16'h0000, 1'b0);
    send0(16'h0001, 1'b0);
    @(negedge clk);
    check("bp_next_data", 32'(bus0.out_data), 32'h0BAB);
    cycle();

    // Reset in the middle of a frame.
    send0(16'h00F0, 1'b0);
    send0(16'h0F00, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (4) send0(16'h0001, 1'b0);
    @(negedge clk);
    check("mid_rst_data",  32'(bus0.out_data),  32'h0001);
    check("mid_rst_count", 32'(bus0.out_count), 32'd4);
    cycle();
    repeat (2) cycle();

    // BEATS=1 instance: three single-word frames back to back.
    for (int i = 0; i < 3; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = v1[i];
      @(negedge clk);
      check("b1_in_ready", 32'(bus1.in_ready), 32'd1);
      cycle();
    end
    bus1.in_valid = 1'b0;
    repeat (4) cycle();
    check("b1_drains",    32'(drains1),  32'd3);
    check("b1_valid_run", 32'(max_run1), 32'd3);

    // Everything pushed must have been drained.
    check("b4_queue_empty", 32'(exp_q.size()),  32'd0);
    check("b1_queue_empty", 32'(exp1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/or16_accum.md
# or16_accum

Sequential 16-bit OR-reduction stage sitting directly downstream of the combinational 16-bit OR gate. It accepts a stream of words over a valid/ready handshake and ORs each frame of words into one result word. A frame ends after BEATS words or on an early `in_last`. Each result is presented with its beat count over a second valid/ready handshake.

## Interface
- `WIDTH`, 16: data word width.
- `BEATS`, 4: maximum words per frame; legal range 1..255.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  word to OR into current frame.
- `in_last`  in  1  qualifies `in_data`; this word closes the frame early.
- `out_valid`  out  1  result word available.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  WIDTH  OR of all words in the completed frame.
- `out_count`  out  8  number of words in the frame (1..BEATS).
- `out_full`  out  1  `out_data` is all ones; combinational from `out_data`.

## Operation
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- Internal state: accumulator `acc[WIDTH]`, counter `cnt[8]`, FSM {ACCUM, HOLD}.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - On accept: `acc <= (cnt==0 ? in_data : acc | in_data)`, `cnt <= cnt+1`.
  - If the new count equals BEATS or `in_last`=1, go to HOLD. Otherwise stay in ACCUM.
- HOLD:
  - `out_valid`=1, `out_data`=`acc`, `out_count`=`cnt`.
  - `in_ready` = `out_ready`: a new frame may start only on the drain cycle.
  - Drain with no accept: `acc<=0`, `cnt<=0`, go to ACCUM.
  - Drain with accept in the same cycle: `acc<=in_data`, `cnt<=1`. Go to HOLD if BEATS==1 or `in_last`, else ACCUM.
  - No drain: hold all state; `out_data`/`out_count` stay stable.
- `in_valid`=0 in ACCUM: no change. A partial frame waits indefinitely.
- `in_last` is ignored unless accepted.
- `cnt` never exceeds BEATS; no wrap-around is reachable.
- Reset (`rst_n`=0 at edge, from any state, including mid-frame or HOLD):
  - FSM=ACCUM, `acc`=0, `cnt`=0, `out_valid`=0.
  - Partial and undrained frames are discarded.
  - While `rst_n` is low, `in_ready` is forced to 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0, `out_full`=0. `in_ready`=0 while reset is held, 1 in the first cycle after release.
- Latency: `out_valid` rises on the cycle after the frame-closing accept.
- Throughput: one word per cycle while `out_ready` is held high, including back-to-back frames with no bubble.
- `in_ready` and `out_full` are combinational. All other outputs are registered.
- Upstream must hold `in_data`/`in_last` stable while `in_valid && !in_ready`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 -> `in_ready`=0, `out_valid`=0, `out_data`=0x0000, `out_count`=0; `in_ready`=1 on first cycle after release.
- Full frame (BEATS=4): feed 0x02F3, 0x0000, 0x0100, 0x8000 with `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=0x83F3, `out_count`=4, `out_full`=0. Pulse lasts 1 cycle.
- Early end plus saturation: feed 0x02F3, then 0xFFFF with `in_last`=1 -> `out_data`=0xFFFF, `out_count`=2, `out_full`=1.
- Backpressure: complete a frame with `out_ready`=0 for 5 cycles while `in_valid`=1 -> `in_ready`=0, `out_data`/`out_count` stable, no words lost. Raise `out_ready`: the result drains and the next word is accepted in the same cycle with `cnt`=1.
- Reset mid-operation: accept 2 words, assert `rst_n`=0 for one cycle, then feed 4 words of 0x0001 -> result 0x0001 with `out_count`=4, with no contribution from the pre-reset words.
- BEATS=1 build: stream 0x02F3, 0x0000, 0xFFFF with `out_ready`=1 continuously -> three consecutive `out_valid` cycles carrying those values, each with `out_count`=1.
